// File: rtl/ppu_write_queue.sv
// Purpose: holds CPU writes to PPU memories and replays them to the address decoder only during vblank; owns the vblank irq.
// Latency: a write accepted at edge N into an empty queue with vblank high drives out_write from edge N+2 to N+3.
// Backpressure: waitrequest is combinational and high while the queue is full, except for control-register writes.
//
// Ports:
//   clk, reset            system clock; asynchronous active-low reset
//   chipselect, write,    CPU slave write port; a write is accepted when
//   address, write_data   chipselect & write & ~waitrequest
//   waitrequest           stall to the CPU
//   vblank                vertical blank from the VGA timing block
//   out_chipselect,       replayed write towards the address decoder,
//   out_write,            strobes high for one cycle per replayed entry
//   out_address,
//   out_write_data
//   irq                   sticky vblank interrupt, set on vblank rise
//   level                 current queue occupancy
//   max_level,            high-water mark and late-frame counter, present
//   late_frames           only when PPU_WQ_STATS_EN is defined
//
// Control register (word address CTRL_ADDR, write only, never queued):
//   bit0 clears irq, bit1 flushes the queue, bit2 clears the statistics
//   (bit2 only has an effect with PPU_WQ_STATS_EN).

module ppu_write_queue #(
    parameter int          DEPTH     = 16,
    parameter logic [11:0] CTRL_ADDR = 12'hFFF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     chipselect,
    input  logic                     write,
    input  logic [11:0]              address,
    input  logic [31:0]              write_data,
    output logic                     waitrequest,
    input  logic                     vblank,
    output logic                     out_chipselect,
    output logic                     out_write,
    output logic [11:0]              out_address,
    output logic [31:0]              out_write_data,
    output logic                     irq,
    output logic [$clog2(DEPTH):0]   level
`ifdef PPU_WQ_STATS_EN
    ,
    output logic [$clog2(DEPTH):0]   max_level,
    output logic [7:0]               late_frames
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic [11:0]   addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_nxt;

    logic          is_ctrl;
    logic          full;
    logic          level_nz;
    logic          accept;
    logic          push;
    logic          ctrl_wr;
    logic          flush;
    logic          irq_clr;
    logic          pop;
    logic          vblank_d;
    logic          vblank_rise;

    // ------------------------------------------------------------------
    // CPU side: accept / stall decode
    // ------------------------------------------------------------------
    assign is_ctrl  = (address == CTRL_ADDR);
    assign full     = (level == LW'(DEPTH));
    assign level_nz = (level != '0);

    // Control writes bypass the queue, so they must never be held off by it.
    assign waitrequest = chipselect & write & full & ~is_ctrl;
    assign accept      = chipselect & write & ~waitrequest;
    assign push        = accept & ~is_ctrl;
    assign ctrl_wr     = accept & is_ctrl;
    assign flush       = ctrl_wr & write_data[1];
    assign irq_clr     = ctrl_wr & write_data[0];

    // A flush on the same edge wins over any pop that would have happened,
    // so nothing stale is replayed after the queue is discarded.
    assign pop = (state_q == ST_DRAIN) & vblank & level_nz & ~flush;

    assign level_nxt = level + LW'(push) - LW'(pop);

    // ------------------------------------------------------------------
    // Drain FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (vblank && level_nz && !flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave as soon as the queue will be empty after this edge,
                // vblank has gone away, or the queue is being flushed.
                if (flush || !vblank || (level_nxt == '0)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Circular buffer storage and pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= address;
            data_mem[wr_ptr] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Decoder-side output registers: one strobe cycle per popped entry,
    // address/data hold their last value between pops.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_chipselect <= 1'b0;
            out_write      <= 1'b0;
            out_address    <= '0;
            out_write_data <= '0;
        end else begin
            out_chipselect <= pop;
            out_write      <= pop;
            if (pop) begin
                out_address    <= addr_mem[rd_ptr];
                out_write_data <= data_mem[rd_ptr];
            end
        end
    end

    // ------------------------------------------------------------------
    // vblank interrupt: a new frame's vblank must not be lost to a
    // simultaneous clear, so the set term takes priority.
    // ------------------------------------------------------------------
    assign vblank_rise = vblank & ~vblank_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vblank_d <= 1'b0;
            irq      <= 1'b0;
        end else begin
            vblank_d <= vblank;
            if (vblank_rise) begin
                irq <= 1'b1;
            end else if (irq_clr) begin
                irq <= 1'b0;
            end
        end
    end

`ifdef PPU_WQ_STATS_EN
    // ------------------------------------------------------------------
    // Statistics: occupancy high-water mark and frames whose vblank ended
    // with writes still pending.
    // ------------------------------------------------------------------
    logic stats_clr;
    logic vblank_fall;

    assign stats_clr   = ctrl_wr & write_data[2];
    assign vblank_fall = ~vblank & vblank_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            max_level   <= '0;
            late_frames <= '0;
        end else if (stats_clr) begin
            max_level   <= '0;
            late_frames <= '0;
        end else begin
            if (level_nxt > max_level) begin
                max_level <= level_nxt;
            end
            if (vblank_fall && level_nz && (late_frames != 8'hFF)) begin
                late_frames <= late_frames + 8'd1;
            end
        end
    end
`endif

endmodule
